// File: rtl/mbssoc_uart_tx.sv
// mbssoc_uart_tx: bus-mapped 8N1 UART transmitter with TX FIFO and drain irq; MBSSOC_UART_PARITY_EN adds a parity bit
module mbssoc_uart_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 'h0000_FF00,
  parameter int FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET = 16'd434
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic                  we,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  tx,
  output logic                  irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
`ifdef MBSSOC_UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam state_t AFTER_DATA = PARITY;
  logic par_odd_q;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t state_q, state_d;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic [15:0] div_q, bdiv_q, bdiv_d, tmr_q, tmr_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] sh_q, sh_d;
  logic tx_q, tx_d, irq_q, irq_en_q, ovf_q, rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q, status_w, ctrl_w;
  logic sel_tx, sel_st, sel_ct, push, push_ok, pop, empty, full, busy, bit_done, drain, rd_st, rd_ct, clr_irq;
  logic unused;
  assign sel_tx = addr == BASE_ADDR;
  assign sel_st = addr == BASE_ADDR + ADDR_WIDTH'(1);
  assign sel_ct = addr == BASE_ADDR + ADDR_WIDTH'(2);
  assign empty = cnt_q == '0;
  assign full = cnt_q[AW];
  assign busy = state_q != IDLE;
  assign push = we & sel_tx;
  assign push_ok = push & (~full | pop);
  assign rd_st = re & ~we & sel_st;
  assign rd_ct = re & ~we & sel_ct;
  assign clr_irq = push | (we & sel_ct & ~wdata[16]);
  assign bit_done = tmr_q == bdiv_q - 16'd1;
  assign status_w = DATA_WIDTH'({ovf_q, irq_en_q, busy, full, empty, cnt_q});
`ifdef MBSSOC_UART_PARITY_EN
  assign ctrl_w = DATA_WIDTH'({par_odd_q, irq_en_q, div_q});
`else
  assign ctrl_w = DATA_WIDTH'({irq_en_q, div_q});
`endif
  assign unused = ^wdata[DATA_WIDTH-1:17];
  assign tx = tx_q;
  assign irq = irq_q;
  assign rdata = rdata_q;
  assign rvalid = rvalid_q;
  // Frame sequencer: pops the FIFO on entry to START and latches the divisor for the whole frame
  always_comb begin
    state_d = state_q;
    tmr_d = bit_done ? '0 : tmr_q + 16'd1;
    idx_d = idx_q;
    sh_d = sh_q;
    bdiv_d = bdiv_q;
    pop = 1'b0;
    drain = 1'b0;
    case (state_q)
      IDLE: begin
        tmr_d = '0;
        pop = ~empty;
        state_d = empty ? IDLE : START;
      end
      START: begin
        idx_d = '0;
        if (bit_done) state_d = DATA;
      end
      DATA: if (bit_done) begin
        idx_d = idx_q + 3'd1;
        state_d = idx_q == 3'd7 ? AFTER_DATA : DATA;
      end
`ifdef MBSSOC_UART_PARITY_EN
      PARITY: if (bit_done) state_d = STOP;
`endif
      STOP: if (bit_done) begin
        pop = ~empty;
        drain = empty;
        state_d = empty ? IDLE : START;
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      sh_d = mem_q[rd_q];
      bdiv_d = div_q == '0 ? 16'd1 : div_q;
    end
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? sh_d[idx_d] : 1'b1;
`ifdef MBSSOC_UART_PARITY_EN
    if (state_d == PARITY) tx_d = ^sh_d ^ par_odd_q;
`endif
  end
  // FIFO storage needs no reset: the pointers define what is valid
  always_ff @(posedge clk)
    if (push_ok) mem_q[wr_q] <= wdata[7:0];
  // Control/status registers, FIFO pointers, sequencer state and registered bus response
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tmr_q <= '0;
      idx_q <= '0;
      sh_q <= '0;
      bdiv_q <= 16'd1;
      tx_q <= 1'b1;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      div_q <= DIV_RESET;
      irq_en_q <= 1'b0;
      irq_q <= 1'b0;
      rdata_q <= '0;
      rvalid_q <= 1'b0;
`ifdef MBSSOC_UART_PARITY_EN
      par_odd_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tmr_q <= tmr_d;
      idx_q <= idx_d;
      sh_q <= sh_d;
      bdiv_q <= bdiv_d;
      tx_q <= tx_d;
      wr_q <= wr_q + AW'(push_ok);
      rd_q <= rd_q + AW'(pop);
      cnt_q <= cnt_q + CW'(push_ok) - CW'(pop);
      ovf_q <= (push & ~push_ok) | (ovf_q & ~rd_st);
      irq_q <= ~clr_irq & (irq_q | (drain & irq_en_q));
      rdata_q <= rd_st ? status_w : rd_ct ? ctrl_w : '0;
      rvalid_q <= rd_st | rd_ct;
      if (we & sel_ct) begin
        div_q <= wdata[15:0];
        irq_en_q <= wdata[16];
`ifdef MBSSOC_UART_PARITY_EN
        par_odd_q <= wdata[17];
`endif
      end
    end
  end
endmodule

// File: tb/tb_mbssoc_uart_tx.sv
// tb_mbssoc_uart_tx: scoreboard bench for mbssoc_uart_tx (bus reads and serial frames)
module tb_mbssoc_uart_tx;
  localparam logic [31:0] BASE = 32'h0000_FF00;
  localparam logic [31:0] ST = BASE + 32'd1;
  localparam logic [31:0] CT = BASE + 32'd2;
  logic clk = 1'b0, rst = 1'b1, re = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic tx, irq, rvalid;
  int checks = 0, errs = 0, div = 434, cyc = 0, frames_done = 0, nfr = 0;
  int p, cnt, fd;
  logic [7:0] exp_tx[$];
  logic [31:0] exp_rd[$];
  int starts[$];

  mbssoc_uart_tx dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .re(re), .we(we),
    .rdata(rdata), .rvalid(rvalid), .tx(tx), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic bus(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    we = w; re = r; addr = a; wdata = d;
    @(posedge clk); #1;
    we = 1'b0; re = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e);
    exp_rd.push_back(e);
    bus(1'b0, 1'b1, a, '0);
  endtask

  task automatic push(input logic [7:0] b);
    exp_tx.push_back(b);
    nfr++;
    bus(1'b1, 1'b0, BASE, {24'h0, b});
  endtask

  task automatic wait_frames(input string name);
    int t = 0;
    while (frames_done < nfr && t < 20000) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk(name, frames_done, nfr);
  endtask

  // serial monitor: checks every clock of each frame against the 8N1 shape of the expected byte
  initial begin : tx_mon
    logic [9:0] fr, bad;
    logic [7:0] e;
    int d;
    bit ok, abort;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0 || tx !== 1'b0) continue;
      d = div;
      starts.push_back(cyc);
      ok = exp_tx.size() > 0;
      e = 8'h00;
      if (ok) e = exp_tx.pop_front();
      else begin
        checks++; errs++;
        $display("FAIL frame_unexpected: got start bit at cycle %0d want none", cyc);
      end
      fr = {1'b1, e, 1'b0};
      bad = '0;
      abort = 1'b0;
      for (int k = 0; k < 10 * d; k++) begin
        if (k > 0) @(negedge clk);
        if (rst) begin abort = 1'b1; break; end
        if (tx !== fr[k / d]) bad[k / d] = 1'b1;
      end
      if (!abort && ok) begin
        checks++;
        frames_done++;
        if (bad != '0) begin
          errs++;
          $display("FAIL frame_%02h: got bad-bit mask %b want 0000000000", e, bad);
        end
      end
    end
  end

  // read monitor: every rvalid must match the oldest outstanding expected read
  initial begin : rd_mon
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rvalid === 1'b1) begin
        checks++;
        if (exp_rd.size() == 0) begin
          errs++;
          $display("FAIL rd_unexpected: got %0h want no response", rdata);
        end else begin
          e = exp_rd.pop_front();
          if (rdata !== e) begin
            errs++;
            $display("FAIL rd_data: got %0h want %0h", rdata, e);
          end
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_tx", tx, 1);
    chk("reset_irq", irq, 0);
    rd(ST, 32'h10);
    rd(CT, 32'h1B2);
    bus(1'b0, 1'b1, BASE + 32'd3, '0);
    bus(1'b1, 1'b0, BASE + 32'd3, 32'h55);
    bus(1'b1, 1'b1, CT, 32'h1B2);
    repeat (3) @(posedge clk); #1;

    bus(1'b1, 1'b0, CT, 32'd4); div = 4;
    starts.delete();
    push(8'hA5);
    p = cyc;
    repeat (9) @(posedge clk); #1;
    rd(ST, 32'h50);
    wait_frames("a5_frame_count");
    chk("a5_start_latency", starts[0], p + 1);
    rd(ST, 32'h10);

    bus(1'b1, 1'b0, CT, 32'd2); div = 2;
    starts.delete();
    push(8'h00); push(8'hFF); push(8'h55);
    repeat (8) @(posedge clk); #1;
    rd(ST, 32'h42);
    repeat (19) @(posedge clk); #1;
    rd(ST, 32'h41);
    repeat (19) @(posedge clk); #1;
    rd(ST, 32'h50);
    wait_frames("b2b_frame_count");
    chk("b2b_gap1", starts[1] - starts[0], 20);
    chk("b2b_gap2", starts[2] - starts[1], 20);

    bus(1'b1, 1'b0, CT, 32'h1_0004); div = 4;
    push(8'h3C);
    cnt = 0;
    repeat (40) begin @(posedge clk); #1; if (irq) cnt++; end
    chk("irq_early", cnt, 0);
    @(posedge clk); #1;
    chk("irq_set", irq, 1);
    wait_frames("3c_frame_count");
    rd(ST, 32'h90);
    push(8'hC3);
    chk("irq_clr_txdata", irq, 0);
    wait_frames("c3_frame_count");
    repeat (2) @(posedge clk); #1;
    chk("irq_set_again", irq, 1);
    bus(1'b1, 1'b0, CT, 32'd4);
    chk("irq_clr_ctrl", irq, 0);
    push(8'h81);
    cnt = 0;
    repeat (50) begin @(posedge clk); #1; if (irq) cnt++; end
    chk("irq_disabled", cnt, 0);
    wait_frames("81_frame_count");

    push(8'h5A);
    repeat (10) @(posedge clk); #1;
    bus(1'b1, 1'b0, CT, 32'd0); div = 1;
    rd(CT, 32'h0);
    wait_frames("div_hold_frame_count");
    push(8'h96);
    wait_frames("div0_frame_count");

    bus(1'b1, 1'b0, CT, 32'd100); div = 100;
    for (int i = 0; i < 9; i++) push(8'h10 + 8'(i));
    bus(1'b1, 1'b0, BASE, 32'h19);
    rd(ST, 32'h168);
    rd(ST, 32'h068);
    wait_frames("ovf_drain_count");

    bus(1'b1, 1'b0, CT, 32'd4); div = 4;
    exp_tx.push_back(8'hA2);
    bus(1'b1, 1'b0, BASE, 32'hA2);
    bus(1'b1, 1'b0, BASE, 32'h0F);
    bus(1'b1, 1'b0, BASE, 32'hF0);
    repeat (15) @(posedge clk); #1;
    chk("pre_rst_tx_low", tx, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_tx", tx, 1);
    rst = 1'b0;
    div = 434;
    rd(ST, 32'h10);
    rd(CT, 32'h1B2);
    fd = frames_done;
    cnt = 0;
    repeat (200) begin @(posedge clk); #1; if (tx !== 1'b1) cnt++; end
    chk("rst_idle_tx", cnt, 0);
    chk("rst_no_frame", frames_done, fd);

    chk("rd_queue_empty", exp_rd.size(), 0);
    chk("tx_queue_empty", exp_tx.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end
endmodule

// File: doc/mbssoc_uart_tx.md
Name: mbssoc_uart_tx

Overview:
- Memory-mapped UART transmitter on the shared SoC data/addr/ctrl bus, downstream of the bus controller.
- Either CPU core writes bytes into an internal FIFO; a serial FSM shifts them out on `tx` as 8N1 frames.
- Raises `irq` when the FIFO and shifter drain. `irq` feeds a spare interrupt vector bit of the APIC.

Parameters:
- DATA_WIDTH, 32, bus data width.
- ADDR_WIDTH, 32, bus address width.
- BASE_ADDR, 32'h0000_FF00, word address of register 0.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, at least 2.
- DIV_RESET, 16'd434, reset value of the baud divisor (clocks per bit).

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- addr, input, ADDR_WIDTH, bus word address (already arbitrated RAM-side address).
- wdata, input, DATA_WIDTH, bus write data.
- re, input, 1, bus read strobe.
- we, input, 1, bus write strobe.
- rdata, output, DATA_WIDTH, read data.
- rvalid, output, 1, `rdata` valid.
- tx, output, 1, serial output, idle high.
- irq, output, 1, level interrupt.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high. All state is updated on the rising edge of `clk`.
- Register map, selected when `addr` equals BASE_ADDR+off; other addresses are ignored:
  - off 0, TXDATA (W): `wdata[7:0]` is pushed to the FIFO.
  - off 1, STATUS (R): {.., ovf, irq_en, busy, full, empty, count[log2(FIFO_DEPTH):0]}, packed LSB-first with count at bit 0.
  - off 2, CTRL (R/W): [15:0] div, [16] irq_en.
- Reset values: tx=1, irq=0, rdata=0, rvalid=0, FIFO empty, count=0, ovf=0, div=DIV_RESET, irq_en=0, FSM=IDLE.
- Reads: `rdata`/`rvalid` are registered with 1-cycle latency. `rdata`=0 when not selected. Reading STATUS clears `ovf` in the same edge that captures it, so the returned value shows the old `ovf`.
- `re` and `we` both asserted to the same register: the write wins, no read response is produced.
- Push: accepted if count<FIFO_DEPTH, or if the FSM pops in the same cycle. Otherwise the byte is dropped and `ovf` is set (sticky).
- Simultaneous push and pop: count is unchanged; pointers wrap modulo FIFO_DEPTH.
- Effective divisor: div=0 is treated as 1.
- A div write mid-frame has no effect on the current frame; it takes effect at the next START.
- FSM states:
  - IDLE: tx=1. If FIFO not empty, pop into the shift register, latch div, go to START.
  - START: tx=0 for div clocks, then DATA, bit index 0.
  - DATA: tx=shift[idx], LSB first, for div clocks per bit. After bit 7 go to STOP, or to PARITY when the option is enabled.
  - STOP: tx=1 for div clocks. Then go to START directly (no idle gap) if the FIFO is not empty, else IDLE.
- Bit timer: counts 0..div-1; the state advances when the count reaches div-1.
- `busy` = FSM is not IDLE.
- Frame length: 10*div clocks (11*div with parity).
- First START begins 1 clock after the push edge: the pop happens in IDLE on the next edge.
- `irq`: set on the STOP→IDLE edge when irq_en=1. Cleared by a TXDATA write, or a CTRL write with irq_en=0. A set and a clear in the same cycle result in clear.
- Reset asserted mid-frame: next edge returns all state to reset values, with tx=1 immediately. The FIFO contents are discarded.

Optional Feature:
- Macro: MBSSOC_UART_PARITY_EN.
- Defined:
  - Adds CTRL[17] par_odd.
  - Adds a PARITY state between DATA and STOP, driving ^byte (even), inverted when par_odd=1, for div clocks.
- Undefined:
  - No PARITY state.
  - CTRL[17] reads 0 and writes to it are ignored.
  - Frame is 8N1.

Test Plan:
- Reset: hold rst 2 clocks → tx=1, irq=0, STATUS read returns empty=1, count=0. CTRL read returns 434.
- Single byte: write CTRL div=4, then TXDATA 8'hA5 → tx sequence 0,1,0,1,0,0,1,0,1,1, each held 4 clocks, 40 clocks total. busy drops 1 clock after the stop bit.
- Back-to-back frames: div=2, push 8'h00,8'hFF,8'h55 in 3 consecutive cycles → three 20-clock frames with no idle gap, count decrements at each pop.
- Overflow: div=100, push 10 bytes in consecutive cycles → first byte popped, 8 buffered, 1 dropped. Next STATUS read shows ovf=1, full=1; the following read shows ovf=0.
- Interrupt: irq_en=1, send 1 byte → irq rises on the STOP→IDLE edge. TXDATA write clears it on the next edge. With irq_en=0, irq never rises.
- Reset mid-frame: assert rst during DATA bit 3 with 2 bytes queued → tx=1 and count=0 after the edge. No further frame after rst releases until a new push.
